// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a shared synchronous memory.
// Each grant runs one XFER cycle on the memory pins, then one DONE cycle carrying ack/rvalid.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  state_e            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              win;

  // On a tie the requester not served last wins; otherwise the lone requester wins.
  always_comb begin
    if (req == 2'b11) win = ~last_gnt_q;
    else              win = req[1];
  end

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    ack_d       = 2'b00;
    rvalid_d    = 2'b00;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d       = win;
          last_gnt_d  = win;
          we_d        = we[win];
          mem_addr_d  = win ? addr1 : addr0;
          mem_wdata_d = win ? wdata1 : wdata0;
          mem_write_d = we[win];
          mem_read_d  = ~we[win];
          busy_d      = 1'b1;
          state_d     = XFER;
        end
      end
      XFER: begin
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        if (!we_q) rdata_d = mem_rdata;
        ack_d[gnt_q]    = 1'b1;
        rvalid_d[gnt_q] = ~we_q;
        state_d         = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d      = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Reset clears the memory strobes at the same edge, so an interrupted XFER never completes.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      ack_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      ack_q       <= ack_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack       = ack_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_;
  logic [1:0]        req, we;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [1:0]        ack, rvalid;
  logic [DATA_W-1:0] rdata;
  logic              busy, mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_(rst_), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack(ack), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory shares the block reset: a write strobe caught by a reset edge is not stored.
  logic [DATA_W-1:0] mem [32];
  always @(posedge clk) if (rst_ && mem_write) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_read ? mem[mem_addr] : '0;

  // Reference model: phase 0 idle, 1 memory cycle, 2 completion cycle.
  int rm_phase, rm_last, rm_gnt, rm_addr, rm_wdata, rm_rdata;
  bit rm_we;
  int rm_mem [32];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_log [$];
  int ack_cyc [$];
  int rd_log  [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (!rst_) begin
      rm_phase = 0;
      rm_last  = 1;
      rm_rdata = 0;
    end else begin
      case (rm_phase)
        0: if (req != 2'b00) begin
          if (req == 2'b11) rm_gnt = 1 - rm_last;
          else              rm_gnt = req[1] ? 1 : 0;
          rm_last  = rm_gnt;
          rm_we    = we[rm_gnt];
          rm_addr  = rm_gnt ? int'(addr1) : int'(addr0);
          rm_wdata = rm_gnt ? int'(wdata1) : int'(wdata0);
          rm_phase = 1;
        end
        1: begin
          if (rm_we) rm_mem[rm_addr] = rm_wdata;
          else       rm_rdata = rm_mem[rm_addr];
          rm_phase = 2;
        end
        default: rm_phase = 0;
      endcase
    end
  endtask

  task automatic compare();
    logic [1:0] e_ack, e_rv;
    e_ack = 2'b00;
    e_rv  = 2'b00;
    if (rm_phase == 2) begin
      e_ack[rm_gnt] = 1'b1;
      e_rv[rm_gnt]  = ~rm_we;
    end
    check_eq("busy", 32'(busy), 32'(rm_phase != 0));
    check_eq("mem_read", 32'(mem_read), 32'(rm_phase == 1 && !rm_we));
    check_eq("mem_write", 32'(mem_write), 32'(rm_phase == 1 && rm_we));
    check_eq("rw_exclusive", 32'(mem_read & mem_write), 32'(0));
    if (rm_phase == 1) begin
      check_eq("mem_addr", 32'(mem_addr), 32'(rm_addr));
      check_eq("mem_wdata", 32'(mem_wdata), 32'(rm_wdata));
    end
    check_eq("ack", 32'(ack), 32'(e_ack));
    check_eq("rvalid", 32'(rvalid), 32'(e_rv));
    check_eq("rdata", 32'(rdata), 32'(rm_rdata));
    if (ack != 2'b00) begin
      ack_log.push_back(int'(ack));
      ack_cyc.push_back(cyc);
    end
    if (rvalid != 2'b00) rd_log.push_back(int'(rdata));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare();
  endtask

  task automatic scramble();
    addr0  = ADDR_W'($urandom);
    addr1  = ADDR_W'($urandom);
    wdata0 = DATA_W'($urandom);
    wdata1 = DATA_W'($urandom);
    we     = 2'($urandom);
    req    = 2'($urandom);
  endtask

  task automatic access(input int k, input bit w, input int a, input int d);
    scramble();
    req    = 2'b00;
    req[k] = 1'b1;
    we[k]  = w;
    if (k == 0) begin addr0 = ADDR_W'(a); wdata0 = DATA_W'(d); end
    else        begin addr1 = ADDR_W'(a); wdata1 = DATA_W'(d); end
    step();
    scramble();
    step();
    req = 2'b00;
    step();
  endtask

  initial begin
    int n0;
    for (int i = 0; i < 32; i++) begin
      mem[i]    = '0;
      rm_mem[i] = 0;
    end
    rm_phase = 0; rm_last = 1; rm_gnt = 0; rm_we = 1'b0;
    rm_addr = 0; rm_wdata = 0; rm_rdata = 0;

    // Reset with both requesting
    rst_ = 1'b0; req = 2'b11; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    step();
    step();
    check_eq("rst_ack", 32'(ack), 32'(0));
    check_eq("rst_rvalid", 32'(rvalid), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_mem_rw", 32'({mem_read, mem_write}), 32'(0));
    check_eq("rst_mem_addr", 32'(mem_addr), 32'(0));
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    check_eq("rst_rdata", 32'(rdata), 32'(0));
    rst_ = 1'b1; addr0 = 5'h01; addr1 = 5'h02;
    step();
    check_eq("first_tie_addr", 32'(mem_addr), 32'(5'h01));
    req = 2'b00;
    step();
    check_eq("first_tie_ack", 32'(ack), 32'(2'b01));
    step();

    // Single write then read, requester 0
    req = 2'b01; we = 2'b01; addr0 = 5'h03; wdata0 = 8'h41;
    step();
    check_eq("wr_mem_write", 32'(mem_write), 32'(1));
    check_eq("wr_mem_addr", 32'(mem_addr), 32'(5'h03));
    req = 2'b00;
    step();
    check_eq("wr_write_one_cycle", 32'(mem_write), 32'(0));
    check_eq("wr_ack", 32'(ack), 32'(2'b01));
    step();
    n0 = rd_log.size();
    access(0, 1'b0, 5'h03, 0);
    check_eq("rd_count", 32'(rd_log.size()), 32'(n0 + 1));
    if (rd_log.size() > n0) check_eq("rd_data", 32'(rd_log[$]), 32'(8'h41));

    // Contention: requester 1 served last, so the tie sequence starts at 0
    access(1, 1'b0, 5'h00, 0);
    ack_log.delete(); ack_cyc.delete();
    req = 2'b11; we = 2'b11; addr0 = 5'h1F; addr1 = 5'h00; wdata0 = 8'hAA; wdata1 = 8'h55;
    repeat (12) step();
    req = 2'b00;
    check_eq("cont_acks", 32'(ack_log.size()), 32'(4));
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      check_eq("cont_order", 32'(ack_log[i]), (i % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
      if (i > 0) check_eq("cont_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(3));
    end

    // Full sweep by requester 1
    for (int i = 0; i < 32; i++) access(1, 1'b1, i, i);
    for (int i = 0; i < 32; i++) begin
      n0 = rd_log.size();
      access(1, 1'b0, i, 0);
      check_eq("sweep_count", 32'(rd_log.size()), 32'(n0 + 1));
      if (rd_log.size() > n0) check_eq("sweep_data", 32'(rd_log[$]), 32'(i));
    end

    // Reset during the XFER of a write
    access(0, 1'b1, 5'h0A, 8'h00);
    n0 = ack_log.size();
    req = 2'b01; we = 2'b01; addr0 = 5'h0A; wdata0 = 8'hFF;
    step();
    check_eq("rx_in_xfer", 32'(mem_write), 32'(1));
    rst_ = 1'b0; req = 2'b00;
    step();
    check_eq("rx_mem_write", 32'(mem_write), 32'(0));
    check_eq("rx_mem_addr", 32'(mem_addr), 32'(0));
    rst_ = 1'b1;
    step();
    step();
    check_eq("rx_no_ack", 32'(ack_log.size()), 32'(n0));
    n0 = rd_log.size();
    access(0, 1'b0, 5'h0A, 0);
    check_eq("rx_rd_count", 32'(rd_log.size()), 32'(n0 + 1));
    if (rd_log.size() > n0) check_eq("rx_rd_data", 32'(rd_log[$]), 32'(8'h00));

    // Request held one cycle past ack yields a second access
    n0 = ack_log.size();
    req = 2'b01; we = 2'b01; addr0 = 5'h07; wdata0 = 8'h5A;
    repeat (4) step();
    req = 2'b00;
    step();
    step();
    check_eq("hold_two_acks", 32'(ack_log.size()), 32'(n0 + 2));
    check_eq("hold_mem", 32'(mem[7]), 32'(8'h5A));

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      scramble();
      rst_ = ($urandom_range(0, 39) != 0);
      step();
    end
    rst_ = 1'b1; req = 2'b00;
    repeat (3) step();
    for (int i = 0; i < 32; i++) check_eq("final_mem", 32'(mem[i]), 32'(rm_mem[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter and sequencer for the shared 8-bit x 32-location synchronous memory. It sits between two bus masters (a test driver and a background scrubber/loader) and the memory's read/write/addr/data pins. It serialises their accesses, guarantees that read and write are never asserted together, and returns read data with a per-requester valid strobe.

## Interface
- ADDR_W, 5, memory address width (32 locations)
- DATA_W, 8, memory data width
- clk  in  1  rising-edge clock
- rst_  in  1  reset; one clock, reset is synchronous and active-low
- req  in  2  per-requester access request; bit k = requester k
- we  in  2  per-requester op: 1 = write, 0 = read; valid with req[k]
- addr0 / addr1  in  ADDR_W  requester 0 / 1 address
- wdata0 / wdata1  in  DATA_W  requester 0 / 1 write data
- ack  out  2  one-cycle completion pulse to requester k
- rvalid  out  2  one-cycle read-data-valid to requester k; coincident with ack[k] on reads
- rdata  out  DATA_W  read data, valid only while an rvalid bit is high
- busy  out  1  high whenever state is not IDLE
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (driven by memory while mem_read high)

## Operation
- FSM states: IDLE, XFER, DONE. All outputs are registered.
- IDLE: if no req, stay. If exactly one req[k], grant k. If both, grant the requester not granted last (last_gnt register). Latch winner's we/addr/wdata, update last_gnt, go to XFER.
- XFER (exactly 1 cycle): mem_addr = latched addr; mem_write = latched we; mem_read = !latched we; mem_wdata = latched wdata (on reads too; the memory ignores it). At the closing edge, capture mem_rdata into rdata on reads. Go to DONE.
- DONE (exactly 1 cycle): ack[k] = 1; rvalid[k] = 1 on reads only; mem_read = mem_write = 0. Go to IDLE.
- A req bit high in IDLE is always a new request. A requester wanting one access drops req in the cycle after it sees ack. Holding req high yields back-to-back accesses.
- Requester inputs need only be stable in the IDLE cycle in which they are granted. Later changes are ignored until the next grant.
- Round-robin fairness: a continuously requesting requester is served within 2 grants.
- mem_read and mem_write are never both 1. Both are 0 outside XFER.
- rdata holds its last captured value between reads. It is only meaningful with rvalid.

## Timing
- Reset (rst_ low at a rising edge) puts the block in IDLE. ack = 0, rvalid = 0, busy = 0, mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0, rdata = 0, last_gnt = 1 (requester 0 wins the first tie).
- Latency: req sampled at edge N (IDLE). mem_* are active in cycle N..N+1. The memory writes and rdata is captured at edge N+1. ack/rvalid are high in cycle N+1..N+2. The block is back in IDLE after edge N+2.
- Throughput: one access per 3 cycles. There are no back-to-back memory cycles, so there is always a dead cycle between a write and a following read.
- Reset mid-operation:
  - During XFER, the registered mem_* outputs clear at the reset edge, so no memory access occurs after it. The transaction is dropped and no ack is issued.
  - During DONE, ack/rvalid clear at the reset edge.
- Simultaneous events: a req rising while the FSM is in XFER or DONE waits for IDLE. Nothing is queued beyond the live req level.

## Test plan
- Reset: assert rst_ low 2 cycles with req = 2'b11. Required: all outputs 0, busy 0. After release, the first tie is granted to requester 0.
- Single write then read, requester 0: write addr0 = 5'h03, wdata0 = 8'h41. Required: mem_write = 1 and mem_addr = 03 for exactly 1 cycle, ack[0] 2 cycles after req is sampled. Then read 03. Required: rvalid[0] = 1, rdata = 8'h41, rvalid[1] = 0.
- Contention: both hold req for 4 grants, writing addr 1F (requester 0) and 00 (requester 1). Required: grant order 0,1,0,1; acks every 3 cycles; mem_read and mem_write are never both high.
- Full sweep: requester 1 writes data = address to all 32 locations, then reads them back. Required: rdata = address on every rvalid[1]; no errors; addr 1F does not wrap into 00.
- Reset mid-XFER: reset asserted in the XFER cycle of a write of 8'hFF to addr 0A, after clearing 0A to 8'h00. Required: no ack. A later read of 0A returns 8'h00 (the reset edge completed no write).
- Hold-after-ack: requester 0 keeps req high one extra cycle after ack while requester 1 is idle. Required: a second access to the same address is performed and acked, confirming level-sensitive request semantics.
